fetch_stage: RTL and testbench

//  PC generation and instruction-fetch stage; owns the PC and IF/DEC pipeline register.

---
 rtl/core_types_pkg.sv | 33 +++
 rtl/fetch_skid_buffer.sv | 45 ++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core pipeline types: fetch FSM states, fetch packets and the branching redirect bundle.
package core_types_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } fetch_pkt_t;

    typedef struct packed {
        logic        flush;
        logic        hold;
        logic [31:0] PCnext;
        logic [31:0] PCcurrent;
        logic        branch;
        logic        bypass;
    } branching_out_t;

    localparam fetch_pkt_t BUBBLE_PKT = '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};

    // Bypass supplies an absolute target; a branch is PC-relative and wraps mod 2^32.
    function automatic logic [31:0] redirect_target(input branching_out_t br);
        return br.bypass ? {br.PCnext[31:1], 1'b0} : (br.PCcurrent + br.PCnext);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry buffer that parks a fetched packet while decode is holding.
module fetch_skid_buffer
    import core_types_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       pop_i,
    input  logic       clear_i,
    input  fetch_pkt_t pkt_i,
    output logic       valid_o,
    output fetch_pkt_t pkt_o
);

    logic       valid_q, valid_d;
    fetch_pkt_t pkt_q, pkt_d;

    // Clear beats load beats pop.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pkt_d   = pkt_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pkt_q   <= BUBBLE_PKT;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/fetch_stage.sv
// PC generation and instruction fetch: owns the PC, the IF/DEC register and the imem request.
module fetch_stage
    import core_types_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic           Clock,
    input  logic           nReset,
    input  branching_out_t branching_in,
    output logic           imem_req,
    output logic [31:0]    imem_addr,
    input  logic           imem_ready,
    input  logic [31:0]    imem_rdata,
    output logic [31:0]    PCIF,
    output logic [31:0]    instrDEC,
    output logic [31:0]    PCDEC,
    output logic           validDEC
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic         outstanding_q, outstanding_d;
    fetch_pkt_t   ifdec_q, ifdec_d;

    logic         skid_valid, skid_load, skid_pop, skid_clear;
    fetch_pkt_t   skid_pkt, fetched_pkt;
    logic         redirect, transfer;
    logic [31:0]  target;

    assign redirect    = branching_in.branch | branching_in.bypass;
    assign target      = redirect_target(branching_in);
    assign imem_req    = nReset & ((state_q == DRAIN) | outstanding_q |
                                   (~skid_valid & ~branching_in.hold));
    assign imem_addr   = pc_q;
    assign transfer    = imem_req & imem_ready;
    assign fetched_pkt = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
    assign outstanding_d = imem_req & ~imem_ready;

    // A redirect that lands on a still-pending request must keep the address stable, so it drains first.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        ifdec_d       = ifdec_q;
        skid_load     = 1'b0;
        skid_pop      = 1'b0;
        skid_clear    = 1'b0;
        case (state_q)
            DRAIN: begin
                ifdec_d = BUBBLE_PKT;
                if (imem_ready) begin
                    state_d = RUN;
                    pc_d    = redirect ? target : redirect_pc_q;
                end else if (redirect) begin
                    redirect_pc_d = target;
                end
            end
            default: begin
                if (redirect) begin
                    ifdec_d    = BUBBLE_PKT;
                    skid_clear = 1'b1;
                    if (imem_req & ~imem_ready) begin
                        state_d       = DRAIN;
                        redirect_pc_d = target;
                    end else begin
                        pc_d = target;
                    end
                end else if (branching_in.flush) begin
                    ifdec_d    = BUBBLE_PKT;
                    skid_clear = 1'b1;
                end else if (branching_in.hold) begin
                    if (transfer) begin
                        skid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end else if (skid_valid) begin
                    ifdec_d  = skid_pkt;
                    skid_pop = 1'b1;
                end else if (transfer) begin
                    ifdec_d = fetched_pkt;
                    pc_d    = pc_q + 32'd4;
                end else begin
                    ifdec_d = BUBBLE_PKT;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q       <= RUN;
            pc_q          <= RESET_VECTOR;
            redirect_pc_q <= RESET_VECTOR;
            outstanding_q <= 1'b0;
            ifdec_q       <= BUBBLE_PKT;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            outstanding_q <= outstanding_d;
            ifdec_q       <= ifdec_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk_i   (Clock),
        .rst_ni  (nReset),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .clear_i (skid_clear),
        .pkt_i   (fetched_pkt),
        .valid_o (skid_valid),
        .pkt_o   (skid_pkt)
    );

    assign PCIF     = pc_q;
    assign instrDEC = ifdec_q.instr;
    assign PCDEC    = ifdec_q.pc;
    assign validDEC = ifdec_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences and random traffic vs a reference model.
module tb_fetch_stage;
    import core_types_pkg::*;

    logic           Clock;
    logic           nReset;
    branching_out_t branching_in;
    logic           imem_req;
    logic [31:0]    imem_addr;
    logic           imem_ready;
    logic [31:0]    imem_rdata;
    logic [31:0]    PCIF;
    logic [31:0]    instrDEC;
    logic [31:0]    PCDEC;
    logic           validDEC;

    int checks;
    int failures;

    typedef struct {
        logic        flush, hold, branch, bypass;
        logic [31:0] pcCur, pcNext;
        logic        ready;
    } stim_t;

    typedef struct {
        stim_t       stim;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expPcif;
        logic        expValid;
        logic [31:0] expPcDec;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } pkt_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Reference model state: fetch PC, drain status, pending request, skid queue, decode slot.
    logic [31:0] mPc;
    logic [31:0] mDrainTarget;
    bit          mDraining;
    bit          mPending;
    pkt_t        mSkid[$];
    pkt_t        mDec;

    vec_t  tbl[22];
    stim_t rs;

    fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .branching_in (branching_in),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .PCIF         (PCIF),
        .instrDEC     (instrDEC),
        .PCDEC        (PCDEC),
        .validDEC     (validDEC)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    function automatic stim_t mkStim(input logic fl, input logic ho, input logic br, input logic by,
                                     input logic [31:0] cur, input logic [31:0] nxt, input logic rdy);
        stim_t s;
        s.flush = fl; s.hold = ho; s.branch = br; s.bypass = by;
        s.pcCur = cur; s.pcNext = nxt; s.ready = rdy;
        return s;
    endfunction

    function automatic vec_t mkVec(input stim_t s, input logic req, input logic [31:0] addr,
                                   input logic [31:0] pcif, input logic vld, input logic [31:0] pcdec);
        vec_t v;
        v.stim = s; v.expReq = req; v.expAddr = addr; v.expPcif = pcif;
        v.expValid = vld; v.expPcDec = pcdec;
        return v;
    endfunction

    function automatic bit modelReq(input stim_t s);
        return mDraining || mPending || (mSkid.size() == 0 && !s.hold);
    endfunction

    task automatic modelReset();
        mPc          = 32'h0;
        mDrainTarget = 32'h0;
        mDraining    = 1'b0;
        mPending     = 1'b0;
        mSkid.delete();
        mDec = '{instr: NOP, pc: 32'h0, valid: 1'b0};
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        branching_in = '{flush: s.flush, hold: s.hold, PCnext: s.pcNext, PCcurrent: s.pcCur,
                         branch: s.branch, bypass: s.bypass};
        imem_ready = s.ready;
        #2;
    endtask

    task automatic checkModel(input string tag, input stim_t s);
        checkOutput({tag, "/req"},      {31'b0, imem_req}, {31'b0, modelReq(s)});
        checkOutput({tag, "/addr"},     imem_addr, mPc);
        checkOutput({tag, "/PCIF"},     PCIF, mPc);
        checkOutput({tag, "/validDEC"}, {31'b0, validDEC}, {31'b0, mDec.valid});
        checkOutput({tag, "/PCDEC"},    PCDEC, mDec.pc);
        checkOutput({tag, "/instrDEC"}, instrDEC, mDec.instr);
    endtask

    task automatic checkRow(input vec_t v, input int i);
        checkOutput($sformatf("row%0d/req", i),      {31'b0, imem_req}, {31'b0, v.expReq});
        checkOutput($sformatf("row%0d/addr", i),     imem_addr, v.expAddr);
        checkOutput($sformatf("row%0d/PCIF", i),     PCIF, v.expPcif);
        checkOutput($sformatf("row%0d/validDEC", i), {31'b0, validDEC}, {31'b0, v.expValid});
        checkOutput($sformatf("row%0d/PCDEC", i),    PCDEC, v.expPcDec);
        checkOutput($sformatf("row%0d/instrDEC", i), instrDEC, v.expValid ? memWord(v.expPcDec) : NOP);
    endtask

    // Advance the reference model by one clock using the stimulus rules, then step past the edge.
    task automatic stepCycle(input stim_t s);
        bit          req, fire, redir;
        logic [31:0] tgt;
        pkt_t        fetched;
        pkt_t        bubble;
        req     = modelReq(s);
        fire    = req && s.ready;
        redir   = s.branch || s.bypass;
        tgt     = s.bypass ? (s.pcNext & 32'hFFFF_FFFE) : (s.pcCur + s.pcNext);
        fetched = '{instr: memWord(mPc), pc: mPc, valid: 1'b1};
        bubble  = '{instr: NOP, pc: 32'h0, valid: 1'b0};
        if (mDraining) begin
            mDec = bubble;
            if (s.ready) begin
                mPc       = redir ? tgt : mDrainTarget;
                mDraining = 1'b0;
            end else if (redir) begin
                mDrainTarget = tgt;
            end
        end else if (redir) begin
            mDec = bubble;
            mSkid.delete();
            if (req && !s.ready) begin
                mDraining    = 1'b1;
                mDrainTarget = tgt;
            end else begin
                mPc = tgt;
            end
        end else if (s.flush) begin
            mDec = bubble;
            mSkid.delete();
        end else if (s.hold) begin
            if (fire) begin
                mSkid.push_back(fetched);
                mPc = mPc + 32'd4;
            end
        end else if (mSkid.size() != 0) begin
            mDec = mSkid.pop_front();
        end else if (fire) begin
            mDec = fetched;
            mPc  = mPc + 32'd4;
        end else begin
            mDec = bubble;
        end
        mPending = req && !s.ready;
        @(posedge Clock);
        #1;
    endtask

    task automatic modelCycle(input string tag, input stim_t s);
        applyStimulus(s);
        checkModel(tag, s);
        stepCycle(s);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h0,    32'h0,    0, 32'h0);
        tbl[1]  = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h4,    32'h4,    1, 32'h0);
        tbl[2]  = mkVec(mkStim(0,0,0,0, 0, 0, 0),             1, 32'h8,    32'h8,    1, 32'h4);
        tbl[3]  = mkVec(mkStim(0,0,0,0, 0, 0, 0),             1, 32'h8,    32'h8,    0, 32'h0);
        tbl[4]  = mkVec(mkStim(0,0,0,0, 0, 0, 0),             1, 32'h8,    32'h8,    0, 32'h0);
        tbl[5]  = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h8,    32'h8,    0, 32'h0);
        tbl[6]  = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'hC,    32'hC,    1, 32'h8);
        tbl[7]  = mkVec(mkStim(0,0,0,0, 0, 0, 0),             1, 32'h10,   32'h10,   1, 32'hC);
        tbl[8]  = mkVec(mkStim(0,0,1,0, 32'h100, 32'h20, 0),  1, 32'h10,   32'h10,   0, 32'h0);
        tbl[9]  = mkVec(mkStim(0,0,0,0, 0, 0, 0),             1, 32'h10,   32'h10,   0, 32'h0);
        tbl[10] = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h10,   32'h10,   0, 32'h0);
        tbl[11] = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h120,  32'h120,  0, 32'h0);
        tbl[12] = mkVec(mkStim(0,0,0,1, 0, 32'h2003, 1),      1, 32'h124,  32'h124,  1, 32'h120);
        tbl[13] = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h2002, 32'h2002, 0, 32'h0);
        tbl[14] = mkVec(mkStim(0,0,0,0, 0, 0, 0),             1, 32'h2006, 32'h2006, 1, 32'h2002);
        tbl[15] = mkVec(mkStim(0,1,0,0, 0, 0, 1),             1, 32'h2006, 32'h2006, 0, 32'h0);
        tbl[16] = mkVec(mkStim(0,1,0,0, 0, 0, 1),             0, 32'h200A, 32'h200A, 0, 32'h0);
        tbl[17] = mkVec(mkStim(0,0,0,0, 0, 0, 1),             0, 32'h200A, 32'h200A, 0, 32'h0);
        tbl[18] = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h200A, 32'h200A, 1, 32'h2006);
        tbl[19] = mkVec(mkStim(1,0,0,0, 0, 0, 1),             1, 32'h200E, 32'h200E, 1, 32'h200A);
        tbl[20] = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h200E, 32'h200E, 0, 32'h0);
        tbl[21] = mkVec(mkStim(0,0,0,0, 0, 0, 1),             1, 32'h2012, 32'h2012, 1, 32'h200E);

        nReset = 1'b0;
        modelReset();
        applyStimulus(mkStim(0,0,0,0, 0, 0, 1));
        #10;
        checkOutput("reset/req",      {31'b0, imem_req}, 32'h0);
        checkOutput("reset/PCIF",     PCIF, 32'h0);
        checkOutput("reset/validDEC", {31'b0, validDEC}, 32'h0);
        checkOutput("reset/PCDEC",    PCDEC, 32'h0);
        checkOutput("reset/instrDEC", instrDEC, NOP);
        @(posedge Clock);
        #1;
        nReset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(tbl[i].stim);
            checkRow(tbl[i], i);
            stepCycle(tbl[i].stim);
        end

        // Two redirects while draining: the newest target must win.
        modelCycle("t6a", mkStim(0,0,0,0, 0, 0, 0));
        modelCycle("t6b", mkStim(0,0,1,0, 32'h0, 32'h40, 0));
        modelCycle("t6c", mkStim(0,0,0,1, 32'h0, 32'h80, 0));
        applyStimulus(mkStim(0,0,0,0, 0, 0, 0));
        checkOutput("t6/drainReq", {31'b0, imem_req}, 32'h1);
        checkOutput("t6/drainAddr", imem_addr, 32'h2016);
        checkModel("t6d", mkStim(0,0,0,0, 0, 0, 0));
        stepCycle(mkStim(0,0,0,0, 0, 0, 0));
        modelCycle("t6e", mkStim(0,0,0,0, 0, 0, 1));
        applyStimulus(mkStim(0,0,0,0, 0, 0, 1));
        checkOutput("t6/resumePC", PCIF, 32'h80);
        checkOutput("t6/resumeAddr", imem_addr, 32'h80);
        stepCycle(mkStim(0,0,0,0, 0, 0, 1));

        // Reset asserted mid-drain abandons the transfer.
        modelCycle("rstA", mkStim(0,0,0,0, 0, 0, 0));
        modelCycle("rstB", mkStim(0,0,1,0, 32'h300, 32'h4, 0));
        applyStimulus(mkStim(0,0,0,0, 0, 0, 0));
        nReset = 1'b0;
        #1;
        checkOutput("rstDrain/req",      {31'b0, imem_req}, 32'h0);
        checkOutput("rstDrain/PCIF",     PCIF, 32'h0);
        checkOutput("rstDrain/validDEC", {31'b0, validDEC}, 32'h0);
        checkOutput("rstDrain/instrDEC", instrDEC, NOP);
        modelReset();
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        modelCycle("rstC", mkStim(0,0,0,0, 0, 0, 0));

        // A redirect coinciding with ready in DRAIN goes straight to the new target.
        modelCycle("coA", mkStim(0,0,1,0, 32'h1000, 32'h10, 0));
        modelCycle("coB", mkStim(0,0,1,0, 32'h2000, 32'h8, 1));
        applyStimulus(mkStim(0,0,0,0, 0, 0, 1));
        checkOutput("co/PCIF", PCIF, 32'h2008);
        checkModel("coC", mkStim(0,0,0,0, 0, 0, 1));
        stepCycle(mkStim(0,0,0,0, 0, 0, 1));

        for (int n = 0; n < 400; n++) begin
            rs.ready  = ($urandom_range(0, 3) != 0);
            rs.hold   = ($urandom_range(0, 3) == 0);
            rs.branch = ($urandom_range(0, 7) == 0);
            rs.bypass = ($urandom_range(0, 9) == 0);
            rs.flush  = ($urandom_range(0, 9) == 0);
            rs.pcCur  = $urandom & 32'hFFFF_FFFC;
            rs.pcNext = $urandom;
            if (!rs.bypass) rs.pcNext[1:0] = 2'b00;
            modelCycle($sformatf("rand%0d", n), rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
